// File: rtl/divider_4bit_recon.sv
// divider_4bit_recon
// Rebuilds the dividend of the 4-bit / 2-bit divider from its outputs:
// A = Q*B + R. The multiply is done MSB-first, one quotient bit per clock.
// The final remainder add takes one more clock.
// noncanon flags a remainder that is not strictly below the divisor.
// A divisor of zero always sets noncanon.
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request; accepted in IDLE or DONE
//   Q[3:0]    quotient operand (captured on accept)
//   B[1:0]    divisor operand (captured on accept)
//   R[3:0]    remainder operand (captured on accept)
//   busy      high while the MUL/ADD steps are running
//   done      one-cycle pulse when A/noncanon are updated
//   A[7:0]    reconstructed dividend, held until the next result
//   noncanon  R >= B, held with A
module divider_4bit_recon (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] Q,
   input  logic [1:0] B,
   input  logic [3:0] R,
   output logic       busy,
   output logic       done,
   output logic [7:0] A,
   output logic       noncanon
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] ADD  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0] state;
   logic [3:0] q_reg;
   logic [1:0] b_reg;
   logic [3:0] r_reg;
   logic [7:0] acc;
   logic [1:0] idx;
   logic [7:0] partial;

   // Shift-add step: double the accumulator and add B when the current quotient bit is set.
   always_comb begin
      partial = {acc[6:0], 1'b0};
      if (q_reg[idx]) begin
         partial = {acc[6:0], 1'b0} + {6'b0, b_reg};
      end else begin
         partial = {acc[6:0], 1'b0};
      end
   end

   // Control FSM and datapath registers; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         q_reg    <= 4'd0;
         b_reg    <= 2'd0;
         r_reg    <= 4'd0;
         acc      <= 8'd0;
         idx      <= 2'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         A        <= 8'd0;
         noncanon <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // done is a single-cycle pulse, so it always drops here
               done <= 1'b0;
               if (start) begin
                  q_reg <= Q;
                  b_reg <= B;
                  r_reg <= R;
                  acc   <= 8'd0;
                  idx   <= 2'd3;
                  busy  <= 1'b1;
                  state <= MUL;
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               // start is ignored here; nothing is queued
               acc <= partial;
               if (idx == 2'd0) begin
                  state <= ADD;
               end else begin
                  idx <= idx - 2'd1;
               end
            end
            ADD: begin
               // the maximum value is 15*3 + 15 = 60, so the top bits of A are always zero
               A        <= acc + {4'b0, r_reg};
               noncanon <= ({2'b0, b_reg} <= r_reg);
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= DONE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_4bit_recon.sv
// Directed testbench for divider_4bit_recon. Expected values are computed by hand as A = Q*B + R.
module tb_divider_4bit_recon;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] Q;
   logic [1:0] B;
   logic [3:0] R;
   logic       busy;
   logic       done;
   logic [7:0] A;
   logic       noncanon;

   int n_checks;
   int n_pass;
   int cyc;
   int n_done;

   divider_4bit_recon dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .Q        (Q),
      .B        (B),
      .R        (R),
      .busy     (busy),
      .done     (done),
      .A        (A),
      .noncanon (noncanon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single comparison point for every check
   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // advance one edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // wait for done with a bound; cyc = edges elapsed since the accept edge
   task automatic wait_done();
      cyc = 0;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   // count done pulses over n cycles
   task automatic count_done(input int n);
      n_done = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (done) n_done++;
      end
   endtask

   // one complete operation with a single-cycle start pulse
   task automatic run_op(input logic [3:0] q, input logic [1:0] b, input logic [3:0] r,
                         input int exp_a, input int exp_nc, input string tag);
      Q = q; B = b; R = r; start = 1'b1;
      tick();
      start = 1'b0;
      Q = 4'hx; B = 2'bxx; R = 4'hx;
      check({tag, " busy after accept"}, int'(busy), 1);
      wait_done();
      check({tag, " latency"}, cyc, 5);
      check({tag, " A"}, int'(A), exp_a);
      check({tag, " noncanon"}, int'(noncanon), exp_nc);
      check({tag, " busy at done"}, int'(busy), 0);
      tick();
      check({tag, " done one cycle"}, int'(done), 0);
      check({tag, " A held"}, int'(A), exp_a);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1; start = 1'b0; Q = 4'd0; B = 2'd0; R = 4'd0;

      // reset, then idle
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle busy", int'(busy), 0);
         check("idle done", int'(done), 0);
         check("idle A", int'(A), 0);
         check("idle noncanon", int'(noncanon), 0);
      end

      // reset has priority over start
      rst = 1'b1; start = 1'b1; Q = 4'd5; B = 2'd3; R = 4'd2;
      tick();
      rst = 1'b0; start = 1'b0;
      check("rst beats start busy", int'(busy), 0);
      tick();
      check("rst beats start no op", int'(busy), 0);

      // basic round trip: 5*3+2 = 17
      run_op(4'd5, 2'd3, 4'd2, 17, 0, "basic");

      // back-to-back with start held: 15*3+0 = 45, then 15*3+2 = 47
      Q = 4'd15; B = 2'd3; R = 4'd0; start = 1'b1;
      tick();
      wait_done();
      check("b2b first latency", cyc, 5);
      check("b2b first A", int'(A), 45);
      check("b2b first noncanon", int'(noncanon), 0);
      R = 4'd2;
      tick();
      start = 1'b0;
      check("b2b no gap busy", int'(busy), 1);
      check("b2b no gap done", int'(done), 0);
      wait_done();
      check("b2b second latency", cyc, 5);
      check("b2b second A", int'(A), 47);
      check("b2b second noncanon", int'(noncanon), 0);
      tick();

      // non-canonical inputs: 9*0+7 = 7, and 2*2+3 = 7 with R >= B
      run_op(4'd9, 2'd0, 4'd7, 7, 1, "b zero");
      run_op(4'd2, 2'd2, 4'd3, 7, 1, "r ge b");

      // start while busy is dropped: 3*1+0 = 3
      Q = 4'd3; B = 2'd1; R = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      Q = 4'd15; B = 2'd3; R = 4'd15; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      check("busy start latency", cyc, 3);
      check("busy start A", int'(A), 3);
      check("busy start noncanon", int'(noncanon), 0);
      count_done(10);
      check("busy start no second done", n_done, 0);
      check("busy start A kept", int'(A), 3);

      // reset in the middle of an operation
      Q = 4'd6; B = 2'd2; R = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst busy", int'(busy), 0);
      check("midrst A", int'(A), 0);
      check("midrst noncanon", int'(noncanon), 0);
      count_done(10);
      check("midrst no done", n_done, 0);
      check("midrst A stays 0", int'(A), 0);

      // fresh run after the abort: 6*2+1 = 13
      run_op(4'd6, 2'd2, 4'd1, 13, 0, "after rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
